ex_mult_pipe: RTL
=================

Name: ex_mult_pipe

Overview:
Parametrised pipelined integer multiply unit for the out-of-order EX stage. It replaces the per-unit iterative multiplier with start/done control. It accepts one multiply per cycle through a valid/ready handshake and carries ROB and destination-PRN tags with each operation. Results are buffered in an output FIFO for CDB arbitration. It also supports a low/high product mode and a full squash on branch mispredict.

Parameters:
WIDTH, 64, operand and result width in bits
STAGES, 4, pipeline depth; must divide WIDTH; each stage retires WIDTH/STAGES multiplier bits
OUT_DEPTH, 4, output FIFO entries; must be >= 1
ROB_W, 6, ROB tag width
PRN_W, 7, physical register tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  squash all in-flight and buffered ops (mispredict recovery)
in_valid  in  1  issue request
in_ready  out  1  unit can accept this cycle
in_opa  in  WIDTH  multiplier (regA)
in_opb  in  WIDTH  multiplicand (regB)
in_imm  in  8  literal field from IR[20:13]
in_opb_sel  in  1  0 = in_opb, 1 = zero-extended in_imm
in_mode_high  in  1  0 = low WIDTH bits of product (MULQ), 1 = high WIDTH bits (UMULH)
in_rob  in  ROB_W  ROB tag
in_prn  in  PRN_W  destination PRN
out_valid  out  1  result at FIFO head
out_ready  in  1  CDB grant / consumer accepts head
out_result  out  WIDTH  product
out_rob  out  ROB_W  ROB tag of head
out_prn  out  PRN_W  PRN of head

Behaviour:
- Reset (async, active-high): all stage valids cleared; FIFO empty; credit counter = 0; out_valid = 0; out_result/out_rob/out_prn = 0; in_ready = 1 once reset deasserts.
- Accept: an op is accepted at a rising edge when in_valid & in_ready & ~flush.
- Operand B: in_opb when in_opb_sel = 0; otherwise {WIDTH-8 zeros, in_imm}. Selected at accept.
- Arithmetic: unsigned WIDTH x WIDTH product held in a 2*WIDTH-bit accumulator.
- Stage k adds partial products for multiplier bits [k*W/S +: W/S] and shifts.
- Result = acc[WIDTH-1:0] when mode_high = 0, otherwise acc[2*WIDTH-1:WIDTH]. No overflow flag.
- Pipeline: advances every cycle and never stalls. Each stage carries a valid bit plus mode, rob and prn.
- Latency: op accepted at edge N is written into the FIFO at edge N+STAGES. If the FIFO was empty, out_valid = 1 during the cycle after edge N+STAGES.
- Credits: credit = in-flight ops + FIFO occupancy. in_ready = (credit < OUT_DEPTH).
  - in_ready is a function of registered state only; it must not depend on out_ready combinationally.
  - Accept increments credit; a pop decrements it; simultaneous accept and pop leaves it unchanged.
  - Because of credits, FIFO overflow is impossible; a pipeline result arriving to a full FIFO is an assertion failure.
- Output FIFO: pop at an edge when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot) and when empty with 1 entry arriving (no bypass; head updates next cycle).
  - out_* reflect the head entry while out_valid = 1.
  - out_* hold their last value when empty and are not required to be zero after the first pop.
  - Pointers wrap modulo OUT_DEPTH.
- Flush:
  - Synchronous; at the edge where flush = 1, clear all stage valids, empty the FIFO, and set credit = 0. out_valid = 0 the next cycle.
  - in_valid in the flush cycle is dropped. A pop presented in the flush cycle is also discarded (no double count).
- Reset mid-operation: all in-flight ops are lost, the same as flush. No result for them ever appears.
- Ordering: results emerge in strict issue order.

Test Plan:
- Single op, STAGES=4: opa=3, opb=5, sel=0, mode=0, rob=0x12, prn=0x2A, out_ready=1 -> out_valid cycle 5 after accept; result=15, rob=0x12, prn=0x2A; out_valid pulses one cycle.
- High mode: opa=0xFFFF_FFFF_FFFF_FFFF, opb=2, mode=1 -> result=1; same ops with mode=0 -> result=0xFFFF_FFFF_FFFF_FFFE.
- Immediate: opb_sel=1, in_imm=0xFF, in_opb=0xDEAD, opa=4 -> result=0x3FC.
- Back-pressure, OUT_DEPTH=4, out_ready=0: in_valid held high with 6 ops -> exactly 4 accepted, then in_ready=0 and FIFO fills in order. Raise out_ready -> in_ready returns the cycle after the first pop; all 6 results in order, none lost or duplicated.
- Back-to-back throughput: 8 ops on consecutive cycles with out_ready=1 and OUT_DEPTH >= STAGES+1 -> 8 consecutive out_valid cycles with correct products.
- Flush and reset: 3 ops in flight plus 1 buffered, assert flush -> out_valid=0 next cycle, credit=0, in_ready=1, no stale result ever emitted. Repeat with reset asserted mid-cycle -> outputs clear immediately, with no clock edge needed.

Source files
------------

// File: rtl/ex_mult_pipe.sv
// rtl/ex_mult_pipe.sv - pipelined unsigned multiplier with tagged output FIFO and credit flow control
module ex_mult_pipe #(
    parameter int WIDTH     = 64,
    parameter int STAGES    = 4,
    parameter int OUT_DEPTH = 4,
    parameter int ROB_W     = 6,
    parameter int PRN_W     = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_opa,
    input  logic [WIDTH-1:0] in_opb,
    input  logic [7:0]       in_imm,
    input  logic             in_opb_sel,
    input  logic             in_mode_high,
    input  logic [ROB_W-1:0] in_rob,
    input  logic [PRN_W-1:0] in_prn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [ROB_W-1:0] out_rob,
    output logic [PRN_W-1:0] out_prn
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int CW    = $clog2(OUT_DEPTH + 1);
    localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef struct packed {
        logic               mode;
        logic [ROB_W-1:0]   rob;
        logic [PRN_W-1:0]   prn;
        logic [WIDTH-1:0]   opa;
        logic [WIDTH-1:0]   opb;
        logic [2*WIDTH-1:0] acc;
    } stage_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [ROB_W-1:0] rob;
        logic [PRN_W-1:0] prn;
    } entry_t;

    logic [STAGES-1:0] st_valid;
    stage_t            st      [STAGES];
    stage_t            st_next [STAGES];
    stage_t            issue;

    entry_t            mem [OUT_DEPTH];
    entry_t            head;
    entry_t            head_next;
    entry_t            push_data;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_after_pop;
    logic [CW-1:0]     count_next;
    logic [CW-1:0]     credit;
    logic              accept;
    logic              push;
    logic              pop;

    // Shift-and-add over one slice of multiplier bits, positioned at its bit offset.
    function automatic logic [2*WIDTH-1:0] partial(input logic [WIDTH-1:0] b,
                                                   input logic [CHUNK-1:0] bits,
                                                   input int base);
        logic [2*WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (bits[i]) begin
                sum = sum + ({{WIDTH{1'b0}}, b} << (base + i));
            end
        end
        return sum;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (credit < CW'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign push      = st_valid[STAGES-1] & ~flush;

    always_comb begin
        issue      = '0;
        issue.mode = in_mode_high;
        issue.rob  = in_rob;
        issue.prn  = in_prn;
        issue.opa  = in_opa;
        issue.opb  = in_opb_sel ? {{(WIDTH-8){1'b0}}, in_imm} : in_opb;
    end

    always_comb begin
        st_next[0]     = issue;
        st_next[0].acc = partial(issue.opb, issue.opa[CHUNK-1:0], 0);
        for (int k = 1; k < STAGES; k++) begin
            st_next[k]     = st[k-1];
            st_next[k].acc = st[k-1].acc
                           + partial(st[k-1].opb, st[k-1].opa[k*CHUNK +: CHUNK], k*CHUNK);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_valid <= '0;
        end else if (flush) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= accept;
            for (int k = 1; k < STAGES; k++) begin
                st_valid[k] <= st_valid[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < STAGES; k++) begin
            st[k] <= st_next[k];
        end
    end

    always_comb begin
        push_data        = '0;
        push_data.result = st[STAGES-1].mode ? st[STAGES-1].acc[2*WIDTH-1:WIDTH]
                                             : st[STAGES-1].acc[WIDTH-1:0];
        push_data.rob    = st[STAGES-1].rob;
        push_data.prn    = st[STAGES-1].prn;
    end

    // Head is registered; a push into a FIFO that empties this edge becomes the head directly.
    always_comb begin
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        rd_next         = pop ? ptr_inc(rd_ptr) : rd_ptr;
        head_next       = (push && count_after_pop == '0) ? push_data : mem[rd_next];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            credit <= credit + CW'(accept) - CW'(pop);
            if (count_next != '0) begin
                head <= head_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always @(posedge clock) begin
        if (!reset && push) begin
            assert (count != CW'(OUT_DEPTH));
        end
    end

    assign out_result = head.result;
    assign out_rob    = head.rob;
    assign out_prn    = head.prn;

endmodule
